clkdiv_multi: RTL

- Parametrised, runtime-programmable fabric clock divider. It generates NUM_CH independent divided clock-enable waveforms from a single fabric clock.
- Each channel provides a registered divided square wave and a one-cycle tick at each rising edge of that wave.
- Divisors are reloaded at runtime without glitches, and a shared sync input phase-aligns all channels.
- Successor to the fixed primitive divider wrapper. Used where the divide ratio must change at runtime or exceeds the primitive's fixed modes.

---
 rtl/clkdiv_multi.sv | 94 +++++++++
 1 files changed

// File: rtl/clkdiv_multi.sv
// Runtime-programmable multi-channel clock divider. Each channel produces a registered
// divided square wave plus a one-cycle tick on its rising edge; divisor changes land on period boundaries.
module clkdiv_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              hclkin,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    input  logic              sync,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [DIV_W-1:0]  cur_div [NUM_CH];
    logic [DIV_W-1:0]  cnt     [NUM_CH];
    logic [DIV_W-1:0]  nxt_div [NUM_CH];
    logic [DIV_W-1:0]  half    [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] boundary;
    logic [NUM_CH-1:0] sel;
    logic              accept;
    logic [DIV_W-1:0]  cfg_div_clamped;

    // An out-of-range cfg_ch matches no channel, so cfg_ready stays low for it.
    always_comb begin
        cfg_ready = 1'b0;
        sel       = '0;
        running   = '0;
        boundary  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            half[i]     = (cur_div[i] >> 1) + DIV_W'(cur_div[i][0]);
            sel[i]      = (int'(cfg_ch) == i);
            running[i]  = (cur_div[i] != '0);
            boundary[i] = running[i] && (cnt[i] == cur_div[i] - DIV_W'(1));
            if (sel[i]) begin
                cfg_ready = !reset && !pend[i];
            end
        end
    end

    assign accept          = cfg_valid && cfg_ready;
    assign cfg_div_clamped = (cfg_div == DIV_W'(1)) ? DIV_W'(2) : cfg_div;
    assign pending         = pend;

    always_ff @(posedge hclkin) begin
        if (reset) begin
            cfg_err <= 1'b0;
            pend    <= '0;
            clk_out <= '0;
            tick    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_div[i] <= DIV_W'(DEFAULT_DIV);
                cnt[i]     <= '0;
                nxt_div[i] <= '0;
            end
        end else begin
            cfg_err <= accept && (cfg_div == DIV_W'(1));
            for (int i = 0; i < NUM_CH; i++) begin
                if (running[i]) begin
                    clk_out[i] <= (cnt[i] < half[i]);
                    tick[i]    <= (cnt[i] == '0);
                end else begin
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end

                // Accept needs pend clear, so a fresh request never applies in its own cycle.
                if (accept && sel[i]) begin
                    nxt_div[i] <= cfg_div_clamped;
                    pend[i]    <= 1'b1;
                end else if (pend[i] && (sync || boundary[i] || !running[i])) begin
                    cur_div[i] <= nxt_div[i];
                    pend[i]    <= 1'b0;
                end

                if (!running[i] || sync || boundary[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DIV_W'(1);
                end
            end
        end
    end

endmodule
